// File: rtl/servant_uart_rx.sv
// servant_uart_rx -- Wishbone-responder UART receiver for the servant SoC.
//
// Deserialises 8N1 frames arriving on i_rx into a small receive FIFO that the
// CPU drains over the ext Wishbone bus. o_irq is high while data is pending.
//
// Optional feature: define SERVANT_UART_RX_PARITY_EN to expect one even-parity
// bit between the data bits and the stop bit (11-bit frames). Without it the
// receiver is 8N1 only and the perr flag reads as constant 0.
//
// Parameters:
//   CLK_DIV        clock cycles per bit (4..65535)
//   FIFO_DEPTH     receive FIFO entries (power of two, 2..16)
//   RESET_STRATEGY "NONE" leaves datapath registers unreset; control is always reset
//
// Ports:
//   i_clk     system clock
//   i_rst     asynchronous active-high reset
//   i_rx      serial input, idle high, asynchronous to i_clk
//   i_wb_cyc  Wishbone cycle/strobe
//   i_wb_we   Wishbone write enable
//   i_wb_dat  write data; bits 9/10/11 write-1-to-clear ovr/ferr/perr
//   o_wb_rdt  read data: [7:0] head, [8] valid, [9] ovr, [10] ferr, [11] perr
//   o_wb_ack  one-cycle acknowledge
//   o_irq     high while the FIFO is non-empty
module servant_uart_rx #(
    parameter int CLK_DIV        = 278,
    parameter int FIFO_DEPTH     = 4,
    parameter     RESET_STRATEGY = "MINI"
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_dat,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_irq
);

    localparam int            AW         = $clog2(FIFO_DEPTH);
    localparam logic [15:0]   BIT_RELOAD = 16'(CLK_DIV - 1);
    localparam logic [15:0]   HALF_BIT   = 16'(CLK_DIV / 2 - 1);
    localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE    = 1;
    localparam logic [AW-1:0] PTR_ONE    = 1;
    localparam bit            RST_DP     = (RESET_STRATEGY != "NONE");

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

    // ------------------------------------------------------------------
    // Input synchroniser; idles high so reset never looks like a start bit.
    // ------------------------------------------------------------------
    logic rx_meta_q, rx_s_q;

    // NOTE: every clocked block uses non-blocking assignments so all flops
    // see pre-edge values; blocking here would make the chain collapse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM. push_q / *_set_q are one-cycle strobes to the FIFO side.
    // ------------------------------------------------------------------
    state_t      state_q;
    logic [15:0] cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic        push_q;
    logic        ferr_set_q;
`ifdef SERVANT_UART_RX_PARITY_EN
    logic        perr_set_q;
    logic        par_bad_q;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            push_q     <= 1'b0;
            ferr_set_q <= 1'b0;
`ifdef SERVANT_UART_RX_PARITY_EN
            perr_set_q <= 1'b0;
            par_bad_q  <= 1'b0;
`endif
            if (RST_DP) shift_q <= '0;
        end else begin
            push_q     <= 1'b0;
            ferr_set_q <= 1'b0;
`ifdef SERVANT_UART_RX_PARITY_EN
            perr_set_q <= 1'b0;
`endif
            case (state_q)
                IDLE: if (!rx_s_q) begin
                    state_q <= START;
                    cnt_q   <= HALF_BIT;
                end
                // Re-check mid start bit so short glitches are rejected.
                START: if (cnt_q != 16'd0) cnt_q <= cnt_q - 16'd1;
                else if (rx_s_q) state_q <= IDLE;
                else begin
                    state_q <= DATA;
                    idx_q   <= '0;
                    cnt_q   <= BIT_RELOAD;
`ifdef SERVANT_UART_RX_PARITY_EN
                    par_bad_q <= 1'b0;
`endif
                end
                DATA: if (cnt_q != 16'd0) cnt_q <= cnt_q - 16'd1;
                else begin
                    shift_q <= {rx_s_q, shift_q[7:1]};   // LSB first
                    idx_q   <= idx_q + 3'd1;
                    cnt_q   <= BIT_RELOAD;
                    if (idx_q == 3'd7) begin
`ifdef SERVANT_UART_RX_PARITY_EN
                        state_q <= PARITY;
`else
                        state_q <= STOP;
`endif
                    end
                end
`ifdef SERVANT_UART_RX_PARITY_EN
                // Even parity: the parity bit equals the XOR of the data bits.
                PARITY: if (cnt_q != 16'd0) cnt_q <= cnt_q - 16'd1;
                else begin
                    if (rx_s_q != ^shift_q) begin
                        par_bad_q  <= 1'b1;
                        perr_set_q <= 1'b1;
                    end
                    state_q <= STOP;
                    cnt_q   <= BIT_RELOAD;
                end
`endif
                STOP: if (cnt_q != 16'd0) cnt_q <= cnt_q - 16'd1;
                else if (rx_s_q) begin
`ifdef SERVANT_UART_RX_PARITY_EN
                    push_q <= !par_bad_q;
`else
                    push_q <= 1'b1;
`endif
                    state_q <= IDLE;
                end else begin
                    ferr_set_q <= 1'b1;
                    state_q    <= BRK;
                end
                // Line held low past the stop bit: wait for idle before rearming.
                BRK:     if (rx_s_q) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO, sticky flags and Wishbone register.
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovr_q, ovr_d, ferr_q, ferr_d, perr_bit;
    logic [31:0]   rdt_q, rdt_d;
    logic          ack_q, ack_d, irq_q, irq_d;
    logic          rd_req, wr_req, pop, push_ok;
    logic [7:0]    head;
`ifdef SERVANT_UART_RX_PARITY_EN
    logic          perr_q, perr_d;
    assign perr_bit = perr_q;
`else
    assign perr_bit = 1'b0;
`endif

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path through the block leaves it unassigned (no inferred latches).
    always_comb begin
        rd_req  = i_wb_cyc && !i_wb_we && !ack_q;
        wr_req  = i_wb_cyc &&  i_wb_we && !ack_q;
        // Pop only what this access actually returned as valid.
        pop     = ack_q && rdt_q[8];
        push_ok = push_q && ((count_q != FULL_CNT) || pop);
        head    = (count_q != '0) ? mem[rd_ptr_q] : 8'h00;

        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop)      count_d = count_q + CNT_ONE;
        else if (!push_ok && pop) count_d = count_q - CNT_ONE;

        // Set wins over a simultaneous write-1-to-clear.
        ovr_d  = (push_q && !push_ok) || (ovr_q && !(wr_req && i_wb_dat[9]));
        ferr_d = ferr_set_q || (ferr_q && !(wr_req && i_wb_dat[10]));
`ifdef SERVANT_UART_RX_PARITY_EN
        perr_d = perr_set_q || (perr_q && !(wr_req && i_wb_dat[11]));
`endif

        rdt_d = rdt_q;
        if (rd_req)      rdt_d = {20'h0, perr_bit, ferr_q, ovr_q, count_q != '0, head};
        else if (wr_req) rdt_d = 32'h0;
        ack_d = i_wb_cyc && !ack_q;
        irq_d = (count_d != '0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef SERVANT_UART_RX_PARITY_EN
            perr_q   <= 1'b0;
`endif
            rdt_q    <= '0;
            ack_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
`ifdef SERVANT_UART_RX_PARITY_EN
            perr_q   <= perr_d;
`endif
            rdt_q    <= rdt_d;
            ack_q    <= ack_d;
            irq_q    <= irq_d;
        end
    end

    // NOTE: the FIFO storage has no reset; count/pointers define validity,
    // which lets it map onto plain RAM or reset-less flops.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr_q] <= shift_q;
    end

`ifdef SERVANT_UART_RX_PARITY_EN
    logic unused_dat;
    assign unused_dat = ^{i_wb_dat[31:12], i_wb_dat[8:0]};
`else
    logic unused_dat;
    assign unused_dat = ^{i_wb_dat[31:11], i_wb_dat[8:0]};
`endif

    assign o_wb_rdt = rdt_q;
    assign o_wb_ack = ack_q;
    assign o_irq    = irq_q;

endmodule

// File: tb/tb_servant_uart_rx.sv
// Self-checking bench for servant_uart_rx (CLK_DIV=16, FIFO_DEPTH=4).
// Expected read words are queued as frames are sent and compared when the
// corresponding Wishbone read is acknowledged.
module tb_servant_uart_rx;

    localparam int DIV = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        cyc = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] dat = '0;
    logic [31:0] rdt;
    logic        ack;
    logic        irq;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    servant_uart_rx #(.CLK_DIV(DIV), .FIFO_DEPTH(4), .RESET_STRATEGY("MINI")) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_rx     (rx),
        .i_wb_cyc (cyc),
        .i_wb_we  (we),
        .i_wb_dat (dat),
        .o_wb_rdt (rdt),
        .o_wb_ack (ack),
        .o_irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Serial frame: start, 8 data bits LSB first, [parity], stop.
    task automatic send_byte(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        @(negedge clk) rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (DIV) @(negedge clk);
        end
`ifdef SERVANT_UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        repeat (DIV) @(negedge clk);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        rx = stop_bit;
        repeat (DIV) @(negedge clk);
        if (!stop_bit) repeat (2 * DIV) @(negedge clk);
        rx = 1'b1;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic wb_read(input string tag);
        logic [31:0] got;
        logic        seen;
        got  = 'x;
        seen = 1'b0;
        @(negedge clk) begin cyc = 1'b1; we = 1'b0; end
        for (int k = 0; k < 4 && !seen; k++) begin
            @(negedge clk);
            if (ack) begin seen = 1'b1; got = rdt; end
        end
        cyc = 1'b0;
        @(negedge clk);
        check({tag, "_ack"}, {31'h0, seen}, 32'h1);
        if (exp_q.size() == 0) check({tag, "_sb_empty"}, 32'h1, 32'h0);
        else check(tag, got, exp_q.pop_front());
    endtask

    task automatic wb_write(input string tag, input logic [31:0] v);
        logic seen;
        seen = 1'b0;
        @(negedge clk) begin cyc = 1'b1; we = 1'b1; dat = v; end
        for (int k = 0; k < 4 && !seen; k++) begin
            @(negedge clk);
            if (ack) seen = 1'b1;
        end
        cyc = 1'b0;
        we  = 1'b0;
        dat = '0;
        @(negedge clk);
        check(tag, {31'h0, seen}, 32'h1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_rdt", rdt, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte, then empty read
        send_byte(8'hA5, 1'b1, 1'b0);
        check("a5_irq", {31'h0, irq}, 32'h1);
        exp_q.push_back(32'h0000_01A5);
        wb_read("a5_read");
        exp_q.push_back(32'h0000_0000);
        wb_read("empty_read");
        check("empty_irq", {31'h0, irq}, 32'h0);

        // Overrun: five bytes into a four-entry FIFO
        for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1, 1'b0);
        check("ovr_irq", {31'h0, irq}, 32'h1);
        for (int b = 1; b <= 4; b++) begin
            exp_q.push_back(32'h300 | 32'(b));
            wb_read("ovr_read");
        end
        wb_write("ovr_clr", 32'h200);
        exp_q.push_back(32'h0000_0000);
        wb_read("ovr_cleared");

        // Framing error with break, then a good byte while ferr is sticky
        send_byte(8'h3C, 1'b0, 1'b0);
        check("ferr_irq", {31'h0, irq}, 32'h0);
        exp_q.push_back(32'h0000_0400);
        wb_read("ferr_read");
        send_byte(8'h77, 1'b1, 1'b0);
        exp_q.push_back(32'h0000_0577);
        wb_read("ferr_77");
        wb_write("ferr_clr", 32'h400);
        exp_q.push_back(32'h0000_0000);
        wb_read("ferr_cleared");

        // Start-bit glitch of CLK_DIV/4 cycles
        @(negedge clk) rx = 1'b0;
        repeat (DIV / 4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        check("glitch_irq", {31'h0, irq}, 32'h0);
        exp_q.push_back(32'h0000_0000);
        wb_read("glitch_read");
        send_byte(8'h11, 1'b1, 1'b0);
        exp_q.push_back(32'h0000_0111);
        wb_read("glitch_11");

        // Reset during bit 4 of 0xFF
        @(negedge clk) rx = 1'b0;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (4 * DIV + DIV / 2) @(negedge clk);
        rst = 1'b1;
        cyc = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_rst_ack", {31'h0, ack}, 32'h0);
            check("mid_rst_irq", {31'h0, irq}, 32'h0);
        end
        cyc = 1'b0;
        rst = 1'b0;
        repeat (6 * DIV) @(negedge clk);
        check("post_rst_irq", {31'h0, irq}, 32'h0);
        send_byte(8'h42, 1'b1, 1'b0);
        exp_q.push_back(32'h0000_0142);
        wb_read("rst_42");
        exp_q.push_back(32'h0000_0000);
        wb_read("rst_only_one");

`ifdef SERVANT_UART_RX_PARITY_EN
        // Parity error discards the byte; correct parity delivers it
        send_byte(8'h03, 1'b1, 1'b1);
        exp_q.push_back(32'h0000_0800);
        wb_read("perr_read");
        wb_write("perr_clr", 32'h800);
        send_byte(8'h03, 1'b1, 1'b0);
        exp_q.push_back(32'h0000_0103);
        wb_read("par_ok");
`endif

        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/servant_uart_rx.md
Name: servant_uart_rx

Overview:
- Wishbone-responder UART receiver for the servant SoC.
- The receive end of the serial stream the SoC bit-bangs out on its GPIO pin.
- Deserialises 8N1 frames on i_rx into a small FIFO; the CPU reads them over the ext Wishbone bus (new servant_mux slot).
- o_irq flags pending data for the timer/EI interrupt path.

Parameters:
- CLK_DIV, 278, clock cycles per bit (32 MHz / 115200); legal range 4..65535.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16.
- RESET_STRATEGY, "MINI", "NONE" disables reset of datapath registers only; control/state registers are always reset.

Ports:
- i_clk  in  1  system clock (wb_clk)
- i_rst  in  1  reset, asynchronous, active-high
- i_rx  in  1  serial input, idle high, asynchronous to i_clk
- i_wb_cyc  in  1  Wishbone cycle/strobe
- i_wb_we  in  1  write enable
- i_wb_dat  in  32  write data
- o_wb_rdt  out  32  read data
- o_wb_ack  out  1  acknowledge
- o_irq  out  1  high while FIFO non-empty

Behaviour:
- Reset (async assert, sync release): o_wb_ack=0, o_irq=0, o_wb_rdt=0, FIFO empty, flags clear, FSM=IDLE. Synchroniser resets to 1.
- i_rx passes through a 2-FF synchroniser (rx_s); all decisions use rx_s. Added input latency is 2 cycles.
- Bit counter: 16 bits, counts CLK_DIV-1 down to 0.
- FSM:
  - IDLE: rx_s=0 -> START, counter=CLK_DIV/2-1.
  - START: at counter 0, sample rx_s. If 1 -> IDLE (glitch rejected, no flag). If 0 -> DATA, bit index 0, counter=CLK_DIV-1.
  - DATA: at each counter 0, shift rx_s in LSB first. After the 8th bit -> STOP.
  - STOP: at counter 0, sample rx_s.
    - rx_s=1: push the byte, then -> IDLE.
    - rx_s=0: set ferr sticky, discard the byte, -> BREAK. BREAK waits for rx_s=1, then -> IDLE.
- Push into a full FIFO: set ovr sticky, drop the new byte, keep the existing contents.
- Read register (i_wb_cyc & !i_wb_we):
  - o_wb_rdt[7:0] = FIFO head (0 if empty).
  - [8] = valid (FIFO non-empty).
  - [9] = ovr, [10] = ferr, [11] = perr.
  - [31:12] = 0.
  - The FIFO pops on the ack cycle if non-empty. Reading an empty FIFO returns valid=0 and has no side effect.
- Write (i_wb_cyc & i_wb_we):
  - i_wb_dat[9], [10], [11] write-1-to-clear ovr, ferr, perr.
  - Other bits are ignored; the FIFO is unchanged.
- Handshake: o_wb_ack <= i_wb_cyc & !o_wb_ack. One-cycle pulse, one cycle after cyc, so the minimum access is 2 cycles. o_wb_rdt is registered and valid when o_wb_ack=1.
- Simultaneous push and pop:
  - FIFO full: both happen, no overrun, count unchanged.
  - FIFO empty: the pop is a no-op and the push succeeds.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally; the count is log2(FIFO_DEPTH)+1 bits.
- Flag set and clear in the same cycle: set wins.
- o_irq is registered: o_irq = (count != 0), updated the cycle after a push or pop.
- Reset mid-frame: the FSM returns to IDLE immediately and the partial byte is lost. After release, a line held low is treated as a new start.

Optional Feature:
- Macro: SERVANT_UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples one even-parity bit.
  - Mismatch sets perr sticky and the byte is discarded at STOP (still checked for ferr).
  - Frame length is 11 bits.
- Undefined:
  - No PARITY state; 8N1 only.
  - perr (rdt[11]) is constant 0 and writes to it are ignored.

Test Plan:
- CLK_DIV=16: send 0xA5 as 8N1 on i_rx, then read -> rdt=0x000001A5 on ack. A second read returns 0x00000000 and o_irq=0.
- Send 5 bytes 0x01..0x05 with no reads, FIFO_DEPTH=4 -> four reads return 0x301..0x304 (ovr=1); a write of 0x200 clears ovr; next read returns 0x000.
- Send 0x3C with stop bit forced 0, then release high -> no byte queued, read returns 0x400. Then send 0x77 -> 0x577.
- Pulse i_rx low for CLK_DIV/4 cycles -> no start accepted, FIFO empty, no flags. A following valid 0x11 reads as 0x111.
- Assert i_rst during bit 4 of 0xFF, release, send 0x42 -> only 0x142 received, o_wb_ack=0 and o_irq=0 during reset.
- With SERVANT_UART_RX_PARITY_EN: send 0x03 with parity=1 (wrong) -> read 0x800. Send 0x03 with parity=0 -> 0x103.
